// File: rtl/eprisc_bus_arbiter_pkg.sv
// eprisc_bus_arbiter_pkg: shared bus state encodings and idle/error constants
package eprisc_bus_arbiter_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_ACK   = 3'd4,
    S_ERR   = 3'd5
  } state_t;
  localparam logic [1:0] BUS_SEL_IDLE = 2'b00;
  localparam logic [7:0] ERR_DATA = 8'hFF;
endpackage

// File: rtl/eprisc_bus_arbiter_rr.sv
// eprisc_bus_arbiter_rr: two-way round-robin grant with a registered last-served pointer
module eprisc_bus_arbiter_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_g_i,
  output logic       gnt_o
);
  logic last_q;
  // remember who was served last; reset favours requester 0 on the first tie
  always_ff @(posedge clk)
    if (rst) last_q <= 1'b1;
    else if (upd_i) last_q <= upd_g_i;
  assign gnt_o = &req_i ? ~last_q : req_i[1];
endmodule

// File: rtl/eprisc_bus_arbiter.sv
// eprisc_bus_arbiter: shares the epRISC byte bus between core and DMA, one full-duplex cycle per grant
module eprisc_bus_arbiter
  import eprisc_bus_arbiter_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned SETUP_CYCLES = 1
) (
  input  logic       iBoardClock,
  input  logic       iBoardReset,
  input  logic [1:0] iReq,
  input  logic [1:0] iDev0,
  input  logic [1:0] iDev1,
  input  logic [7:0] iData0,
  input  logic [7:0] iData1,
  output logic [1:0] oAck,
  output logic       oErr,
  output logic [7:0] oData,
  output logic [1:0] oBusSelect,
  output logic [7:0] oBusMOSI,
  output logic       oBusClock,
  input  logic [7:0] iBusMISO,
  input  logic       iBusInterrupt,
  output logic       oBusIntPending
);
  localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  state_t state_q;
  logic g_q;
  logic [7:0] cnt_q;
  logic [1:0] sync_q;
  logic gnt;
  logic [1:0] gnt_dev;
  logic [7:0] gnt_data;
  assign gnt_dev = gnt ? iDev1 : iDev0;
  assign gnt_data = gnt ? iData1 : iData0;
  eprisc_bus_arbiter_rr u_rr (
    .clk    (iBoardClock),
    .rst    (iBoardReset),
    .req_i  (iReq),
    .upd_i  (state_q == S_ACK || state_q == S_ERR),
    .upd_g_i(g_q),
    .gnt_o  (gnt)
  );
  // bus cycle sequencer; every pin is registered on the edge that enters its phase
  always_ff @(posedge iBoardClock)
    if (iBoardReset) begin
      state_q <= S_IDLE;
      g_q <= 1'b0;
      cnt_q <= '0;
      oAck <= '0;
      oErr <= 1'b0;
      oData <= '0;
      oBusSelect <= BUS_SEL_IDLE;
      oBusMOSI <= '0;
      oBusClock <= 1'b0;
    end else begin
      oAck <= '0;
      oErr <= 1'b0;
      case (state_q)
        S_IDLE:
          if (|iReq) begin
            g_q <= gnt;
            if (gnt_dev == BUS_SEL_IDLE) begin
              state_q <= S_ERR;
              oAck[gnt] <= 1'b1;
              oErr <= 1'b1;
              oData <= ERR_DATA;
            end else begin
              state_q <= S_SETUP;
              oBusSelect <= gnt_dev;
              oBusMOSI <= gnt_data;
              cnt_q <= SETUP_LOAD;
            end
          end
        S_SETUP:
          if (cnt_q == '0) begin
            state_q <= S_HIGH;
            oBusClock <= 1'b1;
            cnt_q <= DIV_LOAD;
          end else cnt_q <= cnt_q - 8'd1;
        S_HIGH:
          if (cnt_q == '0) begin
            state_q <= S_LOW;
            oBusClock <= 1'b0;
            oData <= iBusMISO;
            cnt_q <= DIV_LOAD;
          end else cnt_q <= cnt_q - 8'd1;
        S_LOW:
          if (cnt_q == '0) begin
            state_q <= S_ACK;
            oAck[g_q] <= 1'b1;
            oBusSelect <= BUS_SEL_IDLE;
            oBusMOSI <= '0;
          end else cnt_q <= cnt_q - 8'd1;
        default: state_q <= S_IDLE;
      endcase
    end
  // two-flop synchroniser for the asynchronous peripheral interrupt
  always_ff @(posedge iBoardClock)
    if (iBoardReset) sync_q <= '0;
    else sync_q <= {sync_q[0], iBusInterrupt};
  assign oBusIntPending = sync_q[1];
endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// tb_eprisc_bus_arbiter: directed checks of timing, arbitration, errors, reset abort and interrupt sync
module tb_eprisc_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req = '0;
  logic req_f = 1'b0;
  logic [1:0] dev0 = '0, dev1 = '0;
  logic [7:0] data0 = '0, data1 = '0, miso = '0;
  logic intr = 1'b0;
  logic [1:0] ack, sel, ack_f, sel_f;
  logic err, bclk, pend, err_f, bclk_f, pend_f;
  logic [7:0] odata, mosi, odata_f, mosi_f;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  eprisc_bus_arbiter u_dut (
    .iBoardClock(clk), .iBoardReset(rst), .iReq(req), .iDev0(dev0), .iDev1(dev1),
    .iData0(data0), .iData1(data1), .oAck(ack), .oErr(err), .oData(odata),
    .oBusSelect(sel), .oBusMOSI(mosi), .oBusClock(bclk), .iBusMISO(miso),
    .iBusInterrupt(intr), .oBusIntPending(pend)
  );
  eprisc_bus_arbiter #(.CLK_DIV(1), .SETUP_CYCLES(1)) u_fast (
    .iBoardClock(clk), .iBoardReset(rst), .iReq({1'b0, req_f}), .iDev0(dev0), .iDev1(dev1),
    .iData0(data0), .iData1(data1), .oAck(ack_f), .oErr(err_f), .oData(odata_f),
    .oBusSelect(sel_f), .oBusMOSI(mosi_f), .oBusClock(bclk_f), .iBusMISO(miso),
    .iBusInterrupt(intr), .oBusIntPending(pend_f)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 2'b00 && n < 40);
  endtask
  initial begin
    int n, t, last_t;
    @(negedge clk);
    chk("rst_sel", sel, 2'b00);
    chk("rst_mosi", mosi, 8'h00);
    chk("rst_clk", bclk, 1'b0);
    chk("rst_ack", ack, 2'b00);
    chk("rst_err", err, 1'b0);
    chk("rst_data", odata, 8'h00);
    chk("rst_pend", pend, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dev0 = 2'b01; data0 = 8'hA5; miso = 8'h3C; req = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("wr_sel", sel, i <= 9 ? 2'b01 : 2'b00);
      chk("wr_mosi", mosi, i <= 9 ? 8'hA5 : 8'h00);
      chk("wr_clk", bclk, (i >= 2 && i <= 5) ? 1'b1 : 1'b0);
      chk("wr_ack", ack, i == 10 ? 2'b01 : 2'b00);
    end
    chk("wr_data", odata, 8'h3C);
    req = 2'b00;
    @(negedge clk);
    chk("wr_ack_drop", ack, 2'b00);
    chk("wr_data_hold", odata, 8'h3C);
    dev1 = 2'b00; req = 2'b10;
    @(negedge clk);
    chk("ill_ack", ack, 2'b10);
    chk("ill_err", err, 1'b1);
    chk("ill_data", odata, 8'hFF);
    chk("ill_clk", bclk, 1'b0);
    chk("ill_sel", sel, 2'b00);
    req = 2'b00;
    @(negedge clk);
    chk("ill_ack_drop", ack, 2'b00);
    chk("ill_err_drop", err, 1'b0);
    chk("ill_sel_after", sel, 2'b00);
    do_reset();
    dev0 = 2'b01; data0 = 8'h11; dev1 = 2'b10; data1 = 8'h22; miso = 8'h5A; req = 2'b11;
    t = 0; last_t = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      t += n;
      chk("tie_grant", ack, k % 2 == 1 ? 2'b10 : 2'b01);
      chk("tie_gap", t - last_t, k == 0 ? 10 : 11);
      chk("tie_data", odata, 8'h5A);
      last_t = t;
    end
    req = 2'b00;
    @(negedge clk);
    req = 2'b01;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("abort_in_high", bclk, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_sel", sel, 2'b00);
    chk("abort_mosi", mosi, 8'h00);
    chk("abort_clk", bclk, 1'b0);
    chk("abort_ack", ack, 2'b00);
    chk("abort_data", odata, 8'h00);
    rst = 1'b0;
    req = 2'b11;
    wait_ack(n);
    chk("abort_tie_grant", ack, 2'b01);
    chk("abort_tie_lat", n, 10);
    req = 2'b00;
    @(negedge clk);
    req = 2'b01;
    @(negedge clk);
    @(negedge clk);
    intr = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      chk("int_pend", pend, (j >= 2 && j <= 4) ? 1'b1 : 1'b0);
      if (j == 3) intr = 1'b0;
    end
    chk("int_during_xfer", sel, 2'b01);
    wait_ack(n);
    chk("int_xfer_ack", ack, 2'b01);
    req = 2'b00;
    do_reset();
    req_f = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk("fast_ack", ack_f, c % 5 == 4 ? 2'b01 : 2'b00);
      chk("fast_sel", sel_f, (c % 5 == 4 || c % 5 == 0) ? 2'b00 : 2'b01);
      chk("fast_clk", bclk_f, c % 5 == 2 ? 1'b1 : 1'b0);
    end
    req_f = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
